// File: rtl/fp32_mul_normround.sv
// -----------------------------------------------------------------------------
// fp32_mul_normround
//   Back end of the FP32 multiply path. It takes the raw 2*(MAN_W+1)-bit
//   significand product from the Karatsuba mantissa multiplier, together with
//   the sign, rebiased exponent and operand-class flags that were combined
//   upstream. It then normalises, rounds to nearest-even and packs a binary32
//   result.
//
//   The block is an elastic two-stage pipeline with valid/ready on both sides.
//   It has full throughput and a latency of 2 cycles. Stage 1 normalises the
//   product. Stage 2 rounds, range-checks and packs the result.
//
// Ports
//   clkn_i       clock (all flops on the rising edge)
//   rstn_i       asynchronous active-low reset
//   in_valid_i   input beat valid
//   in_ready_o   stage 1 can accept (combinational from out_ready_i)
//   prod_i       unsigned 1.x * 1.x significand product, PW bits
//   sign_i       sign_a ^ sign_b
//   exp_i        signed ea+eb-BIAS, EXP_W+2 bits
//   is_zero_i    an operand is zero / flushed denormal
//   is_inf_i     an operand is infinite
//   is_nan_i     an operand is NaN, or inf*zero
//   out_valid_o  result valid
//   out_ready_i  consumer accepts
//   result_o     {sign, exp, mantissa}
//   flags_o      {overflow, underflow, inexact}, for this beat only
// -----------------------------------------------------------------------------
module fp32_mul_normround #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                     clkn_i,
    input  logic                     rstn_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [2*(MAN_W+1)-1:0]   prod_i,
    input  logic                     sign_i,
    input  logic [EXP_W+1:0]         exp_i,
    input  logic                     is_zero_i,
    input  logic                     is_inf_i,
    input  logic                     is_nan_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic [2:0]               flags_o
);

    localparam int PW = 2 * (MAN_W + 1);
    // One guard bit above the EXP_W+2 input width. The +1 from normalising
    // and the +1 from a rounding carry therefore can never wrap, even for
    // the largest input exponent.
    localparam int EW = EXP_W + 3;
    // All-ones biased exponent (inf/NaN encoding, and the overflow threshold).
    localparam int EXP_ALL1 = 2 * BIAS + 1;
    localparam logic signed [EW-1:0] E_OVF = EW'(EXP_ALL1);
    localparam logic [EXP_W+MAN_W:0] QNAN =
        {1'b0, EXP_W'(EXP_ALL1), 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic                    sign;
        logic                    zero;
        logic                    inf;
        logic                    nan;
        logic signed [EW-1:0]    e;
        logic [MAN_W-1:0]        mant;
        logic                    g;
        logic                    s;
    } s1_t;

    // ---------------------------------------------------------------- handshake
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic adv1, adv2;

    assign adv2       = !v2_q || out_ready_i;
    assign adv1       = !v1_q || adv2;
    assign in_ready_o = adv1;

    // ---------------------------------------------------------------- stage 1
    s1_t                  s1_n, s1_d, s1_q;
    logic                 top;
    logic signed [EW-1:0] e_ext;

    assign top   = prod_i[PW-1];
    assign e_ext = EW'(signed'(exp_i));

    always_comb begin
        s1_n      = '0;
        s1_n.sign = sign_i;
        s1_n.zero = is_zero_i;
        s1_n.inf  = is_inf_i;
        s1_n.nan  = is_nan_i;
        if (top) begin
            // The product is in [2,4): drop the leading 1 at PW-1 and bump the exponent.
            s1_n.mant = prod_i[PW-2 -: MAN_W];
            s1_n.g    = prod_i[PW-2-MAN_W];
            s1_n.s    = |prod_i[PW-3-MAN_W:0];
            s1_n.e    = e_ext + EW'(1);
        end else begin
            s1_n.mant = prod_i[PW-3 -: MAN_W];
            s1_n.g    = prod_i[PW-3-MAN_W];
            s1_n.s    = |prod_i[PW-4-MAN_W:0];
            s1_n.e    = e_ext;
        end
    end

    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        if (adv1) begin
            v1_d = in_valid_i;
            if (in_valid_i) s1_d = s1_n;
        end
    end

    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else begin
            v1_q <= v1_d;
            s1_q <= s1_d;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic                    rnd_up;
    logic                    carry;
    logic [MAN_W-1:0]        mant_r;
    logic signed [EW-1:0]    e_r;
    logic                    inexact;
    logic [EXP_W+MAN_W:0]    res_n, res_d, res_q;
    logic [2:0]              flg_n, flg_d, flg_q;

    // Round to nearest-even. An all-ones mantissa carries out and leaves
    // mant_r at zero, which is exactly the renormalised value after the exponent bump.
    assign rnd_up          = s1_q.g && (s1_q.s || s1_q.mant[0]);
    assign {carry, mant_r} = {1'b0, s1_q.mant} + (MAN_W+1)'(rnd_up);
    assign e_r             = s1_q.e + EW'(carry);
    assign inexact         = s1_q.g || s1_q.s;

    always_comb begin
        res_n = '0;
        flg_n = '0;
        if (s1_q.nan) begin
            res_n = QNAN;
        end else if (s1_q.inf) begin
            res_n = {s1_q.sign, EXP_W'(EXP_ALL1), {MAN_W{1'b0}}};
        end else if (s1_q.zero) begin
            res_n = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (e_r >= E_OVF) begin
            res_n = {s1_q.sign, EXP_W'(EXP_ALL1), {MAN_W{1'b0}}};
            flg_n = 3'b101;
        end else if (e_r <= 0) begin
            // No subnormal output: flush to a signed zero.
            res_n = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
            flg_n = 3'b011;
        end else begin
            res_n = {s1_q.sign, e_r[EXP_W-1:0], mant_r};
            flg_n = {2'b00, inexact};
        end
    end

    // The output registers only move on adv2. They therefore hold while stalled.
    always_comb begin
        v2_d  = v2_q;
        res_d = res_q;
        flg_d = flg_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                res_d = res_n;
                flg_d = flg_n;
            end
        end
    end

    always_ff @(posedge clkn_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v2_q  <= 1'b0;
            res_q <= '0;
            flg_q <= '0;
        end else begin
            v2_q  <= v2_d;
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end

    assign out_valid_o = v2_q;
    assign result_o    = res_q;
    assign flags_o     = flg_q;

endmodule

// File: tb/tb_fp32_mul_normround.sv
// -----------------------------------------------------------------------------
// tb_fp32_mul_normround
//   Directed vectors with hand-computed results. The driver pushes the
//   expected response when a beat is accepted. A monitor pops and compares
//   each beat the DUT hands off. Inputs change 1 time unit after the rising
//   edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fp32_mul_normround;

    logic        clkn_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [47:0] prod_i = '0;
    logic        sign_i = 1'b0;
    logic [9:0]  exp_i = '0;
    logic        is_zero_i = 1'b0;
    logic        is_inf_i = 1'b0;
    logic        is_nan_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] result_o;
    logic [2:0]  flags_o;

    fp32_mul_normround dut (
        .clkn_i      (clkn_i),
        .rstn_i      (rstn_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .prod_i      (prod_i),
        .sign_i      (sign_i),
        .exp_i       (exp_i),
        .is_zero_i   (is_zero_i),
        .is_inf_i    (is_inf_i),
        .is_nan_i    (is_nan_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .flags_o     (flags_o)
    );

    always #5 clkn_i = ~clkn_i;

    typedef struct {
        logic [31:0] r;
        logic [2:0]  f;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: one hand-off per falling edge where valid & ready are both high.
    always @(negedge clkn_i) begin
        if (rstn_i === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            exp_t e;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got %h/%b with nothing outstanding", result_o, flags_o);
            end else begin
                e = sb_q.pop_front();
                if (result_o !== e.r || flags_o !== e.f) begin
                    n_bad++;
                    $display("FAIL beat: got %h/%b want %h/%b", result_o, flags_o, e.r, e.f);
                end
            end
        end
    end

    task automatic drive(input logic [47:0] p, input logic [9:0] e, input logic sg,
                         input logic z, input logic inf, input logic nan);
        prod_i = p; exp_i = e; sign_i = sg;
        is_zero_i = z; is_inf_i = inf; is_nan_i = nan;
        in_valid_i = 1'b1;
    endtask

    // Holds the beat until it is accepted, then pushes its expected response.
    task automatic send(input logic [47:0] p, input logic [9:0] e, input logic sg,
                        input logic z, input logic inf, input logic nan,
                        input logic [31:0] rr, input logic [2:0] ff);
        exp_t x;
        x.r = rr;
        x.f = ff;
        drive(p, e, sg, z, inf, nan);
        for (int k = 0; k < 64; k++) begin
            @(negedge clkn_i);
            if (in_ready_o === 1'b1) begin
                sb_q.push_back(x);
                @(posedge clkn_i); #1;
                in_valid_i = 1'b0;
                return;
            end
            @(posedge clkn_i); #1;
        end
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: in_ready_o stuck at %b want 1", in_ready_o);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb_q.size() == 0) return;
            @(posedge clkn_i); #1;
        end
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: %0d beats outstanding want 0", sb_q.size());
    endtask

    initial begin
        logic [31:0] held;

        // ---- reset state
        repeat (2) @(posedge clkn_i);
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_result",    result_o,         32'h0);
        chk("rst_flags",     32'(flags_o),     32'd0);
        chk("rst_in_ready",  32'(in_ready_o),  32'd1);
        rstn_i = 1'b1;
        @(posedge clkn_i); #1;

        // ---- 1.5*1.5 and its 2-cycle latency
        send(48'h900000000000, 10'd127, 0, 0, 0, 0, 32'h40100000, 3'b000);
        @(negedge clkn_i);
        chk("lat_cycle1_valid", 32'(out_valid_o), 32'd0);
        @(negedge clkn_i);
        chk("lat_cycle2_valid", 32'(out_valid_o), 32'd1);
        @(posedge clkn_i); #1;
        drain();

        // ---- rounding, range and special values, back to back
        send(48'h400000400000, 10'd127, 0, 0, 0, 0, 32'h3F800000, 3'b001); // tie, even stays
        send(48'h400000C00000, 10'd127, 0, 0, 0, 0, 32'h3F800002, 3'b001); // tie, odd rounds up
        send(48'h7FFFFFC00000, 10'd127, 0, 0, 0, 0, 32'h40000000, 3'b001); // mantissa carry
        send(48'h800000000000, 10'd254, 0, 0, 0, 0, 32'h7F800000, 3'b101); // e=255 overflow
        send(48'h7FFFFFC00000, 10'd254, 0, 0, 0, 0, 32'h7F800000, 3'b101); // overflow via round
        send(48'h400000000000, 10'd254, 1, 0, 0, 0, 32'hFF000000, 3'b000); // largest finite exp
        send(48'h400000000000, 10'd0,   1, 0, 0, 0, 32'h80000000, 3'b011); // e=0 underflow
        send(48'h400000000000, 10'd1,   0, 0, 0, 0, 32'h00800000, 3'b000); // smallest normal
        send(48'h400000000000, 10'h3FB, 0, 0, 0, 0, 32'h00000000, 3'b011); // e=-5 underflow
        send(48'h900000000000, 10'd127, 1, 0, 1, 1, 32'h7FC00000, 3'b000); // nan beats inf
        send(48'h900000000000, 10'd127, 1, 0, 1, 0, 32'hFF800000, 3'b000); // inf
        send(48'h900000000000, 10'd127, 1, 1, 0, 0, 32'h80000000, 3'b000); // zero
        drain();

        // ---- backpressure: two accepted, third refused, output held
        out_ready_i = 1'b0;
        send(48'h900000000000, 10'd127, 0, 0, 0, 0, 32'h40100000, 3'b000);
        send(48'h400000000000, 10'd128, 0, 0, 0, 0, 32'h40000000, 3'b000);
        drive(48'h400000000000, 10'd126, 0, 0, 0, 0);
        @(negedge clkn_i);
        chk("bp_in_ready_full", 32'(in_ready_o), 32'd0);
        chk("bp_out_valid",     32'(out_valid_o), 32'd1);
        held = result_o;
        chk("bp_head_result",   result_o, 32'h40100000);
        repeat (3) @(posedge clkn_i);
        @(negedge clkn_i);
        chk("bp_result_stable", result_o, held);
        chk("bp_still_valid",   32'(out_valid_o), 32'd1);
        @(posedge clkn_i); #1;
        out_ready_i = 1'b1;
        send(48'h400000000000, 10'd126, 0, 0, 0, 0, 32'h3F000000, 3'b000);
        drain();

        // ---- reset with both stages full
        out_ready_i = 1'b0;
        send(48'h900000000000, 10'd127, 0, 0, 0, 0, 32'h40100000, 3'b000);
        send(48'h400000000000, 10'd128, 0, 0, 0, 0, 32'h40000000, 3'b000);
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("mid_rst_result",    result_o,         32'h0);
        chk("mid_rst_in_ready",  32'(in_ready_o),  32'd1);
        sb_q.delete();
        @(posedge clkn_i); #1;
        rstn_i = 1'b1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clkn_i);
            chk("post_rst_no_stale", 32'(out_valid_o), 32'd0);
        end
        @(posedge clkn_i); #1;
        send(48'h400000000000, 10'd126, 1, 0, 0, 0, 32'hBF000000, 3'b000);
        drain();

        repeat (3) @(posedge clkn_i);
        chk("leftover_beats", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
